// File: rtl/screen_write_arbiter_pkg.sv
// Shared screen types for the screen-buffer write path: pixel position,
// colour index, arbiter state encoding and a small wrap-around helper.
package screen_write_arbiter_pkg;

    localparam int SCREEN_ROWS = 480;
    localparam int SCREEN_COLS = 640;
    localparam int ROW_W       = 9;
    localparam int COL_W       = 10;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } position;

    localparam int POS_W = $bits(position);

    typedef logic [2:0] color_t;

    localparam int COLOR_W = $bits(color_t);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Increment with explicit wrap, so the modulus need not be a power of two.
    function automatic int wrap_inc(input int ptr, input int modulus);
        return (ptr + 1 >= modulus) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/screen_write_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set bit of 'valid'
// searching upward from 'ptr' with wrap-around. Reusable for any shared port.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] rot;

    // Adds an offset to the pointer and wraps at NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Rotate so that bit 0 corresponds to the requester at ptr.
    assign rot = NUM_REQ'({valid, valid} >> ptr);

    // Take the lowest set bit of the rotated vector and map it back.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                winner = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/screen_write_arbiter.sv
// Round-robin arbiter with burst locking for the single screen-buffer write
// port. A grant is held until the owner's last beat or MAX_BURST beats, then
// one IDLE bubble precedes the next grant. Writes are registered (1 cycle).
// Optional macro SCREEN_ARB_BOUNDS_CHECK_EN: off-screen beats are accepted
// but not written, and raise the sticky oob_err output.
module screen_write_arbiter
    import screen_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*POS_W-1:0]     req_pos,
    input  logic [NUM_REQ*COLOR_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [POS_W-1:0]             write_pos,
    output logic [COLOR_W-1:0]           write_data,
    output logic                         write_en,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
    ,
    output logic                         oob_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] grant_next, rr_ptr, rr_next, winner;
    logic [CNT_W-1:0] beat_cnt, cnt_next, cnt_inc;
    logic             found, cur_valid, cur_last, xfer, burst_done, in_bounds;
    position          cur_pos;
    color_t           cur_data;

    logic             wr_en_p1;
    position          wr_pos_p1;
    color_t           wr_data_p1;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // Route the current owner's beat onto a single internal lane.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_pos   = '0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_pos   = req_pos[i*POS_W +: POS_W];
                cur_data  = req_data[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign cnt_inc = beat_cnt + CNT_W'(1);

`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
    assign in_bounds = (int'(cur_pos.row) < SCREEN_ROWS) && (int'(cur_pos.col) < SCREEN_COLS);
`else
    assign in_bounds = 1'b1;
`endif

    // Next-state, grant bookkeeping and ready decode.
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        rr_next    = rr_ptr;
        cnt_next   = beat_cnt;
        req_ready  = '0;
        xfer       = 1'b0;
        burst_done = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = winner;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == IDX_W'(i));
                end
                xfer = cur_valid;
                if (xfer) begin
                    cnt_next = cnt_inc;
                    // A forced release at MAX_BURST loses nothing: the owner
                    // keeps valid high and resumes after re-arbitration.
                    if (cur_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                        burst_done = 1'b1;
                        state_next = IDLE;
                        rr_next    = IDX_W'(wrap_inc(int'(grant_id), NUM_REQ));
                        cnt_next   = '0;
                    end
                end
            end
        endcase
    end

    // Arbiter control registers; a burst in flight at reset is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_next;
            beat_cnt <= cnt_next;
        end
    end

    // Write stage: position/colour hold their last value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_p1   <= 1'b0;
            wr_pos_p1  <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= xfer && in_bounds;
            if (xfer && in_bounds) begin
                wr_pos_p1  <= cur_pos;
                wr_data_p1 <= cur_data;
            end
        end
    end

`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
    // Sticky flag for any accepted off-screen beat; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if (xfer && !in_bounds) begin
            oob_err <= 1'b1;
        end
    end
`endif

    assign write_en   = wr_en_p1;
    assign write_pos  = wr_pos_p1;
    assign write_data = wr_data_p1;
    assign busy       = (state == GRANT);

    logic unused_ok;
    assign unused_ok = burst_done;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Bench for screen_write_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model and end to end against
// per-requester queues of the pixels each writer sent.
`timescale 1ns/1ps
module tb_screen_write_arbiter;
    import screen_write_arbiter_pkg::*;

    localparam int NUM_REQ   = 3;
    localparam int MAX_BURST = 64;
    localparam int IDX_W     = $clog2(NUM_REQ);

    typedef struct packed {
        position pos;
        color_t  data;
        logic    last;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid, req_last, req_ready;
    logic [NUM_REQ*POS_W-1:0]   req_pos;
    logic [NUM_REQ*COLOR_W-1:0] req_data;
    logic [POS_W-1:0]           write_pos;
    logic [COLOR_W-1:0]         write_data;
    logic                       write_en, busy;
    logic [IDX_W-1:0]           grant_id;
`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
    logic                       oob_err;
`endif

    screen_write_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_pos    (req_pos),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write_pos  (write_pos),
        .write_data (write_data),
        .write_en   (write_en),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
        ,
        .oob_err    (oob_err)
`endif
    );

    always #5 clk = ~clk;

    beat_t                      txq[NUM_REQ][$];
    logic [POS_W+COLOR_W-1:0]   wrq[NUM_REQ][$];
    logic                       hold[NUM_REQ];
    logic                       vq[NUM_REQ];
    int                         dut_grants[$];
    logic                       prev_busy;
    int                         checks = 0;
    int                         errors = 0;

    // behavioural model state
    logic    m_grant;
    int      m_owner, m_ptr, m_cnt;
    logic    m_wen;
    position m_wpos;
    color_t  m_wdata;
    logic    m_oob;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic on_screen(input position p);
`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
        return (int'(p.row) < SCREEN_ROWS) && (int'(p.col) < SCREEN_COLS);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_grant = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_wen = 1'b0; m_wpos = '0; m_wdata = '0; m_oob = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic enq(input int r, input int row, input int col, input int data, input logic last);
        beat_t b;
        b.pos.row = ROW_W'(row);
        b.pos.col = COL_W'(col);
        b.data    = COLOR_W'(data);
        b.last    = last;
        txq[r].push_back(b);
        if (on_screen(b.pos)) wrq[r].push_back({b.pos, b.data});
    endtask

    task automatic add_burst(input int r, input int n);
        for (int i = 0; i < n; i++)
            enq(r, $urandom_range(0, SCREEN_ROWS-1), $urandom_range(0, SCREEN_COLS-1),
                $urandom_range(0, 7), (i == n-1));
    endtask

    task automatic drive();
        for (int r = 0; r < NUM_REQ; r++) begin
            vq[r] = (txq[r].size() > 0) && !hold[r];
            req_valid[r] = vq[r];
            if (txq[r].size() > 0) begin
                req_last[r] = txq[r][0].last;
                req_pos[r*POS_W +: POS_W] = txq[r][0].pos;
                req_data[r*COLOR_W +: COLOR_W] = txq[r][0].data;
            end else begin
                req_last[r] = 1'b0;
                req_pos[r*POS_W +: POS_W] = '0;
                req_data[r*COLOR_W +: COLOR_W] = '0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] er;
        int gid;
        logic ok;
        er = '0;
        if (m_grant) er[m_owner] = 1'b1;
        chk("busy", busy, m_grant);
        chk("grant_id", grant_id, m_owner);
        chk("req_ready", req_ready, er);
        chk("write_en", write_en, m_wen);
        chk("write_pos", write_pos, m_wpos);
        chk("write_data", write_data, m_wdata);
`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
        chk("oob_err", oob_err, m_oob);
`endif
        if (write_en === 1'b1) begin
            gid = int'(grant_id);
            ok = (gid < NUM_REQ) && (wrq[gid].size() > 0);
            chk("sb_owner_has_beats", ok, 1'b1);
            if (ok) chk("sb_beat", {write_pos, write_data}, wrq[gid].pop_front());
        end
        if (busy === 1'b1 && !prev_busy) dut_grants.push_back(int'(grant_id));
        prev_busy = (busy === 1'b1);
    endtask

    // One clock: check current outputs, present beats, predict, advance.
    task automatic step();
        logic n_grant, n_wen, n_oob, found;
        int n_owner, n_ptr, n_cnt, popr, cand;
        position n_wpos;
        color_t n_wdata;
        beat_t b;
        check_outputs();
        drive();
        n_grant = m_grant; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
        n_wen = 1'b0; n_wpos = m_wpos; n_wdata = m_wdata; n_oob = m_oob;
        popr = -1; found = 1'b0;
        if (!m_grant) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (m_ptr + k) % NUM_REQ;
                if (!found && vq[cand]) begin
                    found = 1'b1; n_owner = cand; n_grant = 1'b1;
                end
            end
        end else if (vq[m_owner]) begin
            b = txq[m_owner][0];
            popr = m_owner;
            n_cnt = m_cnt + 1;
            if (on_screen(b.pos)) begin
                n_wen = 1'b1; n_wpos = b.pos; n_wdata = b.data;
            end else begin
                n_oob = 1'b1;
            end
            if (b.last || n_cnt == MAX_BURST) begin
                n_grant = 1'b0; n_ptr = (m_owner + 1) % NUM_REQ; n_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        m_grant = n_grant; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
        m_wen = n_wen; m_wpos = n_wpos; m_wdata = n_wdata; m_oob = n_oob;
        if (popr >= 0) void'(txq[popr].pop_front());
    endtask

    function automatic int pending();
        int p;
        p = 0;
        for (int r = 0; r < NUM_REQ; r++) p += txq[r].size();
        return p;
    endfunction

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((pending() > 0 || m_grant) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_bound", pending(), 0);
        step();
        step();
    endtask

    task automatic check_grants(input string tag, input int e0, input int e1, input int e2, input int e3, input int n);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, dut_grants.size(), n);
        for (int k = 0; k < n; k++)
            chk(tag, (k < dut_grants.size()) ? dut_grants[k] : -1, e[k]);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_pos = '0; req_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin hold[r] = 1'b0; vq[r] = 1'b0; end
        model_reset();

        // reset state
        @(posedge clk);
        #1;
        check_outputs();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single requester: 48-beat sprite with pos {i,i}
        for (int i = 0; i < 48; i++) enq(1, i, i, i % 8, (i == 47));
        drain(200);
        // rr_ptr must now be 2: with 1 and 2 both valid, 2 wins
        enq(1, 1, 1, 1, 1'b1);
        enq(2, 2, 2, 2, 1'b1);
        step();
        chk("rr_after_single", grant_id, 2);
        drain(50);
        enq(2, 3, 3, 3, 1'b1);
        drain(50);

        // round robin: order 0,1,2,0 with 2-beat bursts
        dut_grants.delete();
        add_burst(0, 2); add_burst(0, 2);
        add_burst(1, 2); add_burst(2, 2);
        drain(100);
        check_grants("rr_order", 0, 1, 2, 0, 4);

        // forced release at MAX_BURST with another writer waiting
        dut_grants.delete();
        for (int i = 0; i < 100; i++) enq(0, i, i + 1, i % 8, (i == 99));
        step();
        add_burst(2, 10);
        drain(400);
        check_grants("forced_order", 0, 2, 0, 0, 3);

        // stall: owner drops valid mid-burst while others wait
        dut_grants.delete();
        add_burst(1, 8);
        repeat (4) step();
        hold[1] = 1'b1;
        add_burst(0, 2); add_burst(2, 2);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_busy", busy, 1'b1);
            chk("stall_grant", grant_id, 1);
            chk("stall_wen", write_en, 1'b0);
        end
        hold[1] = 1'b0;
        drain(100);
        check_grants("stall_order", 1, 2, 0, 0, 3);

        // reset mid-burst, asserted between clock edges
        add_burst(2, 20);
        guard = 0;
        while (txq[2].size() > 10 && guard < 60) begin step(); guard++; end
        chk("reset_reach_beat10", txq[2].size(), 10);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_wen", write_en, 1'b0);
        chk("rst_async_pos", write_pos, 0);
        chk("rst_async_data", write_data, 0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_grant", grant_id, 0);
        chk("rst_async_ready", req_ready, 0);
        for (int r = 0; r < NUM_REQ; r++) begin txq[r].delete(); wrq[r].delete(); end
        drive();
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        dut_grants.delete();
        enq(1, 7, 7, 5, 1'b1);
        enq(2, 8, 8, 6, 1'b1);
        step();
        chk("rr_after_reset", grant_id, 1);
        drain(50);

`ifdef SCREEN_ARB_BOUNDS_CHECK_EN
        // off-screen beat: accepted, not written, sticky error
        enq(0, SCREEN_ROWS, 5, 3, 1'b1);
        drain(50);
        chk("oob_set", oob_err, 1'b1);
        add_burst(0, 3);
        drain(50);
        chk("oob_sticky", oob_err, 1'b1);
`endif

        // random traffic with stalls and occasional over-long bursts
        for (int it = 0; it < 400; it++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (txq[r].size() == 0 && $urandom_range(0, 3) == 0)
                    add_burst(r, ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 8));
                hold[r] = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        for (int r = 0; r < NUM_REQ; r++) hold[r] = 1'b0;
        drain(3000);

        for (int r = 0; r < NUM_REQ; r++) chk("sb_leftover", wrq[r].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_write_arbiter.md
Name: screen_write_arbiter

Overview:
- Shares the single screen-buffer write port among NUM_REQ pixel writers: the cursor drawer inside game_sync, the board/digit renderer and the clear engine.
- Uses round-robin arbitration with burst locking, so a sprite drawn as a burst of beats is never interleaved with another writer's pixels.
- Sits between the writers and the screen memory; the downstream write interface is write_pos/write_data.

Parameters:
- NUM_REQ, 3, number of requesters (min 2).
- MAX_BURST, 64, beats a grant may hold before forced release; a sprite of up to 48 pixels fits in one grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_pos  in  NUM_REQ x $bits(position)  per-requester pixel position (screen::position).
- req_data  in  NUM_REQ x 3  per-requester 3-bit colour index.
- req_ready  out  NUM_REQ  per-requester beat accept.
- write_pos  out  $bits(position)  registered pixel position to the screen buffer.
- write_data  out  3  registered colour index.
- write_en  out  1  write strobe, one pixel per cycle.
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset values (async on rst high):
  - state IDLE; rr_ptr 0; beat_cnt 0.
  - req_ready all 0; write_en 0; write_pos 0; write_data 0; grant_id 0; busy 0.
  - A burst in flight at reset is abandoned; the requester must restart it.
- IDLE state:
  - req_ready all 0.
  - If any req_valid is high, pick the first valid requester searching from rr_ptr upward, with wrap-around modulo NUM_REQ.
  - Register the winner in grant_id and go to GRANT next cycle.
  - If no request is valid, stay in IDLE.
- GRANT state:
  - req_ready[grant_id] = 1 (combinational from state); all other ready bits 0.
  - A beat transfers when req_valid[g] && req_ready[g].
  - Each transferred beat increments beat_cnt.
  - The granted requester dropping valid without asserting last is a stall: the grant is held and no write is issued.
- Release from GRANT:
  - Occurs on a transferred beat with req_last = 1, or on the transfer that brings beat_cnt to MAX_BURST.
  - Next state IDLE; rr_ptr = (grant_id + 1) mod NUM_REQ; beat_cnt cleared.
  - On a forced release, no beats are lost. The requester keeps valid high, re-arbitrates and resumes from its next beat.
- Latency:
  - req_valid rising in IDLE at cycle t gives req_ready at t+1.
  - The first beat transfers at t+1; write_en/pos/data appear at t+2.
  - Thereafter one beat per cycle with 1-cycle write latency.
  - There is one mandatory IDLE bubble between consecutive grants, including back-to-back grants to the same requester.
- Write outputs:
  - write_en = 1 only in the cycle after a transfer.
  - write_pos/write_data hold their last value when write_en = 0.
- busy = (state == GRANT).
- Simultaneous events:
  - Beats from non-granted requesters are ignored and must be held by the requester.
  - A release and a new valid in the same cycle are handled via the IDLE bubble; arbitration uses the updated rr_ptr.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - The rr_ptr increment wraps explicitly at NUM_REQ; NUM_REQ need not be a power of two.

Optional Feature:
- Macro: SCREEN_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A transferred beat with pos.row >= SCREEN_ROWS or pos.col >= SCREEN_COLS is accepted (ready handshake unchanged) but suppressed: write_en stays 0.
  - It sets a sticky output oob_err, reset only by rst.
  - It still counts toward beat_cnt.
- Undefined:
  - No check is made; all beats are written.
  - The oob_err port is absent.

Decomposition:
- The screen package holds:
  - the position typedef (packed struct with row and col fields);
  - SCREEN_ROWS and SCREEN_COLS;
  - the colour-index typedef color_t (3 bits);
  - arb_state_t enum {IDLE, GRANT}.
- One natural sub-module, rr_picker: combinational. Inputs are the valid vector and rr_ptr; outputs are found and winner index. It is parameterised by NUM_REQ and reusable for other shared memory ports.

Test Plan:
- Single requester:
  - Stimulus: req 1 sends 48 beats, pos = {i, i}, data = i[2:0], last on beat 47.
  - Response: ready at t+1; 48 consecutive write_en pulses starting at t+2 with matching pos/data; busy drops after the last beat; rr_ptr = 2.
- Round-robin:
  - Stimulus: all three requesters valid, each with 2-beat bursts.
  - Response: grant order 0,1,2,0 with one idle cycle between grants; no write interleaving within a burst.
- Forced release:
  - Stimulus: req 0 sends 100 beats with last only on beat 99, MAX_BURST = 64; req 2 is also valid.
  - Response: req 0 releases after 64 beats; req 2 is served; req 0 resumes at beat 64 with no beat lost or duplicated.
- Stall:
  - Stimulus: the granted requester drops valid for 5 cycles mid-burst while others are valid.
  - Response: grant held; write_en 0 for those cycles; no other requester is granted.
- Reset mid-burst:
  - Stimulus: assert rst asynchronously (off clock edge) during beat 10.
  - Response: all outputs 0 immediately; after release, arbitration restarts from rr_ptr 0.
- Bounds (macro defined):
  - Stimulus: beat with row = SCREEN_ROWS.
  - Response: handshake completes, no write_en, oob_err = 1 and sticky.
